// File: rtl/resonator_dds_deadlock_reporter.sv
// Persistence filter and one-shot reporter for the resonator DDS deadlock monitor.
// Optional block history register is enabled by defining RESONATOR_DDS_DEADLOCK_HIST_EN.
module resonator_dds_deadlock_reporter #(
    parameter int INFO_W   = 4,
    parameter int THRESH_W = 16,
    parameter int TS_W     = 32,
    parameter int GLITCH_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                block,
    input  logic [INFO_W-1:0]   axis_block_info,
    input  logic [THRESH_W-1:0] threshold,
    input  logic                clear,
    output logic                deadlock,
    output logic [INFO_W-1:0]   deadlock_info,
    output logic [TS_W-1:0]     deadlock_time,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [GLITCH_W-1:0] glitch_count,
    output logic [INFO_W-1:0]   block_hist
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        LATCHED = 2'd2
    } state_t;

    state_t                state_reg;
    logic [THRESH_W-1:0]   run_cnt_reg;
    logic [TS_W-1:0]       ts_reg;
    logic [GLITCH_W-1:0]   glitch_reg;
    logic                  deadlock_reg;
    logic                  report_valid_reg;
    logic [INFO_W-1:0]     info_reg;
    logic [TS_W-1:0]       time_reg;

    logic [THRESH_W-1:0]   thr_eff;
    logic [THRESH_W:0]     run_inc;
    logic                  thr_cross;
    logic                  thr_is_one;
    logic [THRESH_W-1:0]   run_sat_next;
    logic [GLITCH_W-1:0]   glitch_sat_next;

    always_comb begin
        thr_eff         = (threshold == '0) ? {{(THRESH_W-1){1'b0}}, 1'b1} : threshold;
        thr_is_one      = (thr_eff == {{(THRESH_W-1){1'b0}}, 1'b1});
        // One extra bit so a saturated counter still compares as crossing.
        run_inc         = {1'b0, run_cnt_reg} + {{THRESH_W{1'b0}}, 1'b1};
        thr_cross       = (run_inc >= {1'b0, thr_eff});
        run_sat_next    = (&run_cnt_reg) ? run_cnt_reg : run_inc[THRESH_W-1:0];
        glitch_sat_next = (&glitch_reg) ? glitch_reg : glitch_reg + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            run_cnt_reg      <= '0;
            ts_reg           <= '0;
            glitch_reg       <= '0;
            deadlock_reg     <= 1'b0;
            report_valid_reg <= 1'b0;
            info_reg         <= '0;
            time_reg         <= '0;
        end else begin
            ts_reg <= ts_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    if (clear) begin
                        run_cnt_reg <= '0;
                        glitch_reg  <= '0;
                    end else if (block) begin
                        if (thr_is_one) begin
                            state_reg        <= LATCHED;
                            deadlock_reg     <= 1'b1;
                            report_valid_reg <= 1'b1;
                            info_reg         <= axis_block_info;
                            time_reg         <= ts_reg;
                            run_cnt_reg      <= {{(THRESH_W-1){1'b0}}, 1'b1};
                        end else begin
                            state_reg   <= COUNT;
                            run_cnt_reg <= {{(THRESH_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                COUNT: begin
                    if (clear) begin
                        state_reg   <= IDLE;
                        run_cnt_reg <= '0;
                        glitch_reg  <= '0;
                    end else if (block) begin
                        run_cnt_reg <= run_sat_next;
                        if (thr_cross) begin
                            state_reg        <= LATCHED;
                            deadlock_reg     <= 1'b1;
                            report_valid_reg <= 1'b1;
                            info_reg         <= axis_block_info;
                            time_reg         <= ts_reg;
                        end
                    end else begin
                        state_reg   <= IDLE;
                        run_cnt_reg <= '0;
                        glitch_reg  <= glitch_sat_next;
                    end
                end
                LATCHED: begin
                    // Captured info/time survive the clear for post-mortem reads.
                    if (clear) begin
                        state_reg        <= IDLE;
                        run_cnt_reg      <= '0;
                        deadlock_reg     <= 1'b0;
                        report_valid_reg <= 1'b0;
                    end else if (report_valid_reg && report_ready) begin
                        report_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    run_cnt_reg <= '0;
                end
            endcase
        end
    end

`ifdef RESONATOR_DDS_DEADLOCK_HIST_EN
    logic [INFO_W-1:0] hist_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hist_reg <= '0;
        end else if (block && (state_reg != LATCHED)) begin
            hist_reg <= hist_reg | axis_block_info;
        end
    end

    assign block_hist = hist_reg;
`else
    assign block_hist = '0;
`endif

    assign deadlock      = deadlock_reg;
    assign deadlock_info = info_reg;
    assign deadlock_time = time_reg;
    assign report_valid  = report_valid_reg;
    assign glitch_count  = glitch_reg;

endmodule

// File: tb/tb_resonator_dds_deadlock_reporter.sv
// Self-checking bench for resonator_dds_deadlock_reporter: vector table plus hand sequences.
module tb_resonator_dds_deadlock_reporter;

    logic        clock;
    logic        reset;
    logic        block;
    logic [3:0]  axis_block_info;
    logic [15:0] threshold;
    logic        clear;
    logic        deadlock;
    logic [3:0]  deadlock_info;
    logic [31:0] deadlock_time;
    logic        report_valid;
    logic        report_ready;
    logic [7:0]  glitch_count;
    logic [3:0]  block_hist;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef RESONATOR_DDS_DEADLOCK_HIST_EN
    localparam logic [3:0] HIST_EXP = 4'hF;
`else
    localparam logic [3:0] HIST_EXP = 4'h0;
`endif

    resonator_dds_deadlock_reporter #(
        .INFO_W(4), .THRESH_W(16), .TS_W(32), .GLITCH_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .block(block),
        .axis_block_info(axis_block_info),
        .threshold(threshold),
        .clear(clear),
        .deadlock(deadlock),
        .deadlock_info(deadlock_info),
        .deadlock_time(deadlock_time),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .glitch_count(glitch_count),
        .block_hist(block_hist)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          rep;
        logic        blk;
        logic [3:0]  info;
        logic [15:0] thr;
        logic        clr;
        logic        rdy;
        logic        dl;
        logic        rv;
        int          gl;     // -1: not checked
        logic [3:0]  dinfo;
        logic [31:0] dtime;
    } vec_t;

    typedef struct {
        logic        dl;
        logic        rv;
        int          gl;
        logic [3:0]  dinfo;
        logic [31:0] dtime;
    } exp_t;

    localparam int NV = 26;
    vec_t vecs [NV];
    exp_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        block = 1'b0;
        axis_block_info = 4'h0;
        clear = 1'b0;
        report_ready = 1'b0;
        threshold = 16'd4;
        repeat (2) tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_deadlock"}, {31'd0, deadlock}, 32'd0);
        chk({tag, "_valid"}, {31'd0, report_valid}, 32'd0);
        chk({tag, "_info"}, {28'd0, deadlock_info}, 32'd0);
        chk({tag, "_time"}, deadlock_time, 32'd0);
        chk({tag, "_glitch"}, {24'd0, glitch_count}, 32'd0);
        chk({tag, "_hist"}, {28'd0, block_hist}, 32'd0);
    endtask

    initial begin
        exp_t e;
        // rep blk info thr clr rdy | dl rv gl dinfo dtime  (expected after the clock edge)
        vecs[0]  = '{2,  1'b0, 4'h0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0,  0, 4'h0, 32'd0};
        vecs[1]  = '{3,  1'b1, 4'h5, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0,  0, 4'h0, 32'd0};
        vecs[2]  = '{1,  1'b0, 4'h0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0,  1, 4'h0, 32'd0};
        vecs[3]  = '{4,  1'b0, 4'h0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0,  1, 4'h0, 32'd0};
        vecs[4]  = '{3,  1'b1, 4'hE, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0,  1, 4'h0, 32'd0};
        vecs[5]  = '{1,  1'b1, 4'hE, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1,  1, 4'hE, 32'd13};
        vecs[6]  = '{2,  1'b0, 4'h3, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1,  1, 4'hE, 32'd13};
        vecs[7]  = '{3,  1'b1, 4'h3, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1,  1, 4'hE, 32'd13};
        vecs[8]  = '{1,  1'b1, 4'h3, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0,  1, 4'hE, 32'd13};
        vecs[9]  = '{2,  1'b1, 4'h3, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0,  1, 4'hE, 32'd13};
        vecs[10] = '{1,  1'b0, 4'h0, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, -1, 4'hE, 32'd13};
        vecs[11] = '{3,  1'b1, 4'h6, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, -1, 4'hE, 32'd13};
        vecs[12] = '{1,  1'b1, 4'h6, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4'h6, 32'd26};
        vecs[13] = '{1,  1'b1, 4'h6, 16'd4, 1'b1, 1'b1, 1'b0, 1'b0, -1, 4'h6, 32'd26};
        vecs[14] = '{1,  1'b0, 4'h0, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0,  0, 4'h6, 32'd26};
        vecs[15] = '{3,  1'b1, 4'h9, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0,  0, 4'h6, 32'd26};
        vecs[16] = '{1,  1'b1, 4'h9, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1,  0, 4'h9, 32'd32};
        vecs[17] = '{1,  1'b0, 4'h0, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0,  0, 4'h9, 32'd32};
        vecs[18] = '{3,  1'b1, 4'h7, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0,  0, 4'h9, 32'd32};
        vecs[19] = '{1,  1'b1, 4'h7, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0,  0, 4'h9, 32'd32};
        vecs[20] = '{1,  1'b0, 4'h0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0,  0, 4'h9, 32'd32};
        vecs[21] = '{1,  1'b1, 4'hA, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1,  0, 4'hA, 32'd39};
        vecs[22] = '{1,  1'b0, 4'h0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0,  0, 4'hA, 32'd39};
        vecs[23] = '{1,  1'b0, 4'h0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0,  0, 4'hA, 32'd39};
        vecs[24] = '{2,  1'b1, 4'h5, 16'd8, 1'b0, 1'b0, 1'b0, 1'b0,  0, 4'hA, 32'd39};
        vecs[25] = '{1,  1'b1, 4'h5, 16'd3, 1'b0, 1'b0, 1'b1, 1'b1,  0, 4'h5, 32'd44};

        do_reset();
        chk_zero("reset");

        for (int i = 0; i < NV; i++) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                block           = vecs[i].blk;
                axis_block_info = vecs[i].info;
                threshold       = vecs[i].thr;
                clear           = vecs[i].clr;
                report_ready    = vecs[i].rdy;
                sb.push_back('{vecs[i].dl, vecs[i].rv, vecs[i].gl, vecs[i].dinfo, vecs[i].dtime});
                tick();
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("deadlock", {31'd0, deadlock}, {31'd0, e.dl});
                    chk("report_valid", {31'd0, report_valid}, {31'd0, e.rv});
                    if (e.gl >= 0) chk("glitch_count", {24'd0, glitch_count}, e.gl);
                    chk("deadlock_info", {28'd0, deadlock_info}, {28'd0, e.dinfo});
                    chk("deadlock_time", deadlock_time, e.dtime);
                end
                $display("cyc %0d blk %b info %h thr %0d clr %b rdy %b -> dl %b rv %b gl %0d info %h time %0d",
                         cyc, block, axis_block_info, threshold, clear, report_ready,
                         deadlock, report_valid, glitch_count, deadlock_info, deadlock_time);
                cyc++;
            end
        end
        block = 1'b0; clear = 1'b0; report_ready = 1'b0;

        // Block history: two channels flagged on consecutive cycles, then a glitch end.
        do_reset();
        block = 1'b1; axis_block_info = 4'hE; tick();
        axis_block_info = 4'hB; tick();
        block = 1'b0; axis_block_info = 4'h0; tick();
        chk("hist_or", {28'd0, block_hist}, {28'd0, HIST_EXP});
        chk("hist_glitch", {24'd0, glitch_count}, 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("hist_clear", {28'd0, block_hist}, 32'd0);
        chk("glitch_clear", {24'd0, glitch_count}, 32'd0);
        $display("hist seq: block_hist %h glitch %0d", block_hist, glitch_count);

        // Glitch counter saturation over 300 sub-threshold episodes.
        do_reset();
        for (int n = 1; n <= 300; n++) begin
            block = 1'b1; tick(); tick();
            block = 1'b0; tick();
            if (n == 254) chk("glitch_254", {24'd0, glitch_count}, 32'd254);
            if (n == 255) chk("glitch_255", {24'd0, glitch_count}, 32'd255);
        end
        chk("glitch_sat", {24'd0, glitch_count}, 32'd255);
        chk("glitch_no_dl", {31'd0, deadlock}, 32'd0);
        $display("glitch seq: glitch_count %0d after 300 episodes", glitch_count);

        // Reset while a report is pending discards it.
        do_reset();
        threshold = 16'd1; block = 1'b1; axis_block_info = 4'h3; tick();
        block = 1'b0;
        chk("thr1_deadlock", {31'd0, deadlock}, 32'd1);
        chk("thr1_time", deadlock_time, 32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_zero("midreset");
        $display("reset seq: deadlock %b report_valid %b", deadlock, report_valid);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/resonator_dds_deadlock_reporter.md
Name: resonator_dds_deadlock_reporter

Overview:
- Sits directly downstream of the HLS deadlock monitor for the resonator DDS instance. Consumes its `block` and `axis_block_info` outputs.
- Filters out transient AXIS stalls with a programmable persistence threshold.
- On a confirmed deadlock: latches the blocking-channel info and a timestamp, raises a sticky flag, and offers a one-shot report record over a valid/ready handshake to the control/status logic.

Parameters:
- INFO_W, 4, width of axis_block_info bus (2 bits per monitored AXIS channel)
- THRESH_W, 16, width of persistence threshold and run counter
- TS_W, 32, width of free-running timestamp counter
- GLITCH_W, 8, width of saturating sub-threshold episode counter

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- block  in  1  monitor's block flag
- axis_block_info  in  INFO_W  monitor's per-channel block info; opaque bits
- threshold  in  THRESH_W  consecutive block cycles required to declare deadlock; 0 treated as 1
- clear  in  1  synchronous clear of latched deadlock and report
- deadlock  out  1  sticky confirmed-deadlock flag
- deadlock_info  out  INFO_W  axis_block_info captured at confirmation
- deadlock_time  out  TS_W  timestamp captured at confirmation
- report_valid  out  1  report record available
- report_ready  in  1  consumer accepts report
- glitch_count  out  GLITCH_W  saturating count of block episodes that ended below threshold
- block_hist  out  INFO_W  sticky OR history (optional feature; else 0)

Behaviour:
- Reset: all outputs 0. State=IDLE, run_cnt=0, ts=0.
- Timestamp ts:
  - Increments by 1 every cycle; wraps 2^TS_W-1 -> 0.
  - Runs in all states. Cleared only by reset.
- Effective threshold thr = (threshold==0) ? 1 : threshold.
- threshold is sampled every cycle. A change mid-episode takes effect on the next compare.
- FSM, all transitions registered:
  - IDLE:
    - block=1 -> COUNT, run_cnt=1.
    - If thr==1, go directly to LATCHED instead, with captures as below.
  - COUNT:
    - block=1: run_cnt+1. When run_cnt+1 >= thr -> LATCHED.
      - Capture: deadlock_info = axis_block_info of that cycle; deadlock_time = ts of that cycle.
      - Set deadlock=1 and report_valid=1 from the next cycle.
    - block=0: -> IDLE, run_cnt=0, glitch_count += 1, saturating at all-ones.
  - LATCHED:
    - deadlock held at 1. block input ignored; no recapture.
    - report_valid held until report_ready=1 is sampled. The transfer occurs in that cycle; report_valid=0 from the next cycle.
    - After acceptance, no new report until clear.
    - clear=1 -> IDLE. Next cycle: deadlock=0, report_valid=0, run_cnt=0. deadlock_info and deadlock_time keep their values.
- Latency: with block rising at cycle t and thr=N, deadlock and report_valid rise at cycle t+N. deadlock_time equals ts at cycle t+N-1.
- run_cnt saturates at all-ones and never wraps.
- clear handling:
  - clear in IDLE or COUNT: returns to IDLE, run_cnt=0, no glitch increment. glitch_count is also zeroed.
  - clear has priority over a simultaneous threshold crossing: no latch occurs.
  - clear with report_ready in the same cycle: clear wins; report_valid drops.
- report_valid is never withdrawn without acceptance, except on clear or reset.
- Reset mid-operation: immediate return to the reset state; a pending report is discarded.

Optional Feature:
- Macro: RESONATOR_DDS_DEADLOCK_HIST_EN.
- Defined:
  - block_hist |= axis_block_info on every cycle where block=1, in any state except LATCHED.
  - Sticky; cleared by reset or clear.
- Undefined: block_hist tied to 0; no history register.

Test Plan:
- threshold=4, block high 3 cycles then low -> no deadlock; glitch_count=1; report_valid stays 0.
- threshold=4, block high continuously from cycle 10 with info=4'hE, ts reset at cycle 0 -> deadlock=1 and report_valid=1 at cycle 14; deadlock_info=4'hE; deadlock_time=13.
- Latched, report_ready low 5 cycles then high 1 cycle -> report_valid drops the cycle after acceptance. deadlock stays 1; block toggling changes nothing.
- Latched, clear=1 together with report_ready=1 -> next cycle deadlock=0, report_valid=0; deadlock_info/time retained. A new block episode of 4 cycles re-latches.
- threshold=0, single-cycle block pulse -> deadlock=1 the following cycle.
- 300 sub-threshold episodes with GLITCH_W=8 -> glitch_count=255. With the HIST macro, info 4'hE then 4'hB -> block_hist=4'hF.
